// File: rtl/prog_loader.sv
// Boot/program loader: streams words into instruction memory, releases the core, counts run cycles.
// Latency: each accepted word is written 1 cycle later; RELEASE is 1 cycle; halt rises 1 cycle after budget hit.
// Backpressure: s_ready is high for every LOAD cycle, so at most one word per cycle, and is low in all other states.
//
// Ports
//   clk, rst        single rising-edge clock, asynchronous active-high reset
//   start, abort    start latches base_addr/word_count/run_cycles (IDLE/HALT only); abort returns to IDLE
//   base_addr       byte address of the first word and the initial PC
//   word_count      words to load (0 skips straight to RELEASE)
//   run_cycles      cycle budget once released; 0 = run forever
//   s_valid/s_data/s_ready   word stream input
//   imem_we/imem_addr/imem_wdata   instruction-memory write port
//   core_hold, pc_init, pc_load    core control
//   cycle_cnt, busy, halt          status
module prog_loader #(
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] base_addr,
  input  logic [CW-1:0] word_count,
  input  logic [DW-1:0] run_cycles,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          imem_we,
  output logic [DW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          core_hold,
  output logic [DW-1:0] pc_init,
  output logic          pc_load,
  output logic [DW-1:0] cycle_cnt,
  output logic          busy,
  output logic          halt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN,
    ST_HALT
  } state_t;

  state_t state, state_d;

  // Latched job parameters. The write address is kept as a running byte
  // address (base + STEP*i) so no multiplier is needed; it wraps mod 2^DW.
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [DW-1:0] run_q, run_d;
  logic [DW-1:0] wr_addr_q, wr_addr_d;

  // Next values of the registered outputs.
  logic          imem_we_d;
  logic [DW-1:0] imem_addr_d;
  logic [DW-1:0] imem_wdata_d;
  logic [DW-1:0] pc_init_d;
  logic [DW-1:0] cycle_cnt_d;

  logic xfer;
  logic last_word;
  logic budget_hit;

  // s_ready is itself a registered copy of "state is LOAD", so a transfer is
  // only ever seen while loading.
  assign xfer       = s_valid && s_ready;
  assign last_word  = (idx_q == (count_q - CW'(1)));
  assign budget_hit = (run_q != '0) && (cycle_cnt == run_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    count_d      = count_q;
    idx_d        = idx_q;
    run_d        = run_q;
    wr_addr_d    = wr_addr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    pc_init_d    = pc_init;
    cycle_cnt_d  = cycle_cnt;

    if (abort) begin
      // abort outranks start and everything else; pc_init and the write
      // address/data simply hold.
      state_d     = ST_IDLE;
      cycle_cnt_d = '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            count_d     = word_count;
            run_d       = run_cycles;
            pc_init_d   = base_addr;
            wr_addr_d   = base_addr;
            idx_d       = '0;
            cycle_cnt_d = '0;
            state_d     = (word_count != '0) ? ST_LOAD : ST_RELEASE;
          end
        end

        ST_LOAD: begin
          if (xfer) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wr_addr_q;
            imem_wdata_d = s_data;
            wr_addr_d    = wr_addr_q + DW'(STEP);
            idx_d        = idx_q + CW'(1);
            if (last_word) begin
              state_d = ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          // Counter shows 1 during the first cycle the core actually runs.
          state_d     = ST_RUN;
          cycle_cnt_d = DW'(1);
        end

        ST_RUN: begin
          // With an unlimited budget the counter free-runs and wraps.
          if (budget_hit) begin
            state_d = ST_HALT;
          end else begin
            cycle_cnt_d = cycle_cnt + DW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output and datapath registers. The per-state control outputs are
  // decoded from the next state so they line up exactly with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      idx_q      <= '0;
      run_q      <= '0;
      wr_addr_q  <= '0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      pc_init    <= '0;
      pc_load    <= 1'b0;
      cycle_cnt  <= '0;
      busy       <= 1'b0;
      halt       <= 1'b0;
    end else begin
      count_q    <= count_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      wr_addr_q  <= wr_addr_d;
      s_ready    <= (state_d == ST_LOAD);
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      core_hold  <= (state_d != ST_RUN);
      pc_init    <= pc_init_d;
      pc_load    <= (state_d == ST_RELEASE);
      cycle_cnt  <= cycle_cnt_d;
      busy       <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      halt       <= (state_d == ST_HALT);
    end
  end

endmodule
